// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage pipelined IEEE-754 binary multiplier with a
// valid/ready handshake, per-operation rounding mode, gradual underflow,
// exception flags {invalid, overflow, underflow, inexact} and a sideband tag.
module fp_mult_pipe #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  parameter int TAG_W  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_a,
  input  logic [EXP_W+FRAC_W:0]   in_b,
  input  logic [1:0]              in_rm,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic [3:0]              out_flags,
  output logic [TAG_W-1:0]        out_tag
);
  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int MW   = FRAC_W + 1;
  localparam int PW   = 2 * MW;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 inf;
    logic                 nan;
    logic                 snan;
    logic signed [EW-1:0] exp;
    logic [MW-1:0]        man;
  } opnd_t;

  function automatic int lzc(input logic [MW-1:0] m);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (m[i]) found = 1'b1;
      else if (!found) n = n + 1;
    end
    return n;
  endfunction

  // Subnormals come out with the leading one at the MSB and a matching
  // (more negative) unbiased exponent, so S2/S3 treat every finite operand alike.
  function automatic opnd_t unpack(input logic [W-1:0] x);
    opnd_t             o;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    int                lz;
    e      = x[W-2:FRAC_W];
    f      = x[FRAC_W-1:0];
    o.sign = x[W-1];
    o.zero = (e == '0) && (f == '0);
    o.inf  = (e == '1) && (f == '0);
    o.nan  = (e == '1) && (f != '0);
    o.snan = o.nan && !f[FRAC_W-1];
    if (e == '0) begin
      lz    = lzc({1'b0, f});
      o.man = {1'b0, f} << lz;
      o.exp = EW'(1 - BIAS - lz);
    end else begin
      o.man = {1'b1, f};
      o.exp = EW'(int'(e) - BIAS);
    end
    return o;
  endfunction

  function automatic logic rnd_inc(input logic [1:0] rm, input logic sign,
                                   input logic lsb, input logic g,
                                   input logic r, input logic s);
    case (rm)
      RM_RNE:  return g & (r | s | lsb);
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign & (g | r | s);
      default: return !sign & (g | r | s);
    endcase
  endfunction

  // Overflow saturates to infinity only when the rounding direction points away from zero.
  function automatic logic [W-1:0] sat_ovf(input logic sign, input logic [1:0] rm);
    logic to_inf;
    to_inf = (rm == RM_RNE) | ((rm == RM_RUP) & !sign) | ((rm == RM_RDN) & sign);
    if (to_inf) return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else        return {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
  endfunction

  logic                 adv1, adv2, adv3;
  opnd_t                ua, ub;
  logic                 spc_d, spc_inv_d;
  logic [W-1:0]         spc_res_d;

  logic                 vld_p1_q, sign_p1_q, spc_p1_q, spc_inv_p1_q;
  logic [W-1:0]         spc_res_p1_q;
  logic signed [EW-1:0] ea_p1_q, eb_p1_q;
  logic [MW-1:0]        ma_p1_q, mb_p1_q;
  logic [1:0]           rm_p1_q;
  logic [TAG_W-1:0]     tag_p1_q;

  logic                 vld_p2_q, sign_p2_q, spc_p2_q, spc_inv_p2_q;
  logic [W-1:0]         spc_res_p2_q;
  logic signed [EW-1:0] esum_p2_q;
  logic [PW-1:0]        prod_p2_q;
  logic [1:0]           rm_p2_q;
  logic [TAG_W-1:0]     tag_p2_q;

  logic                 vld_p3_q;
  logic [W-1:0]         res_p3_q, res_p3_d;
  logic [3:0]           flg_p3_q, flg_p3_d;
  logic [TAG_W-1:0]     tag_p3_q;

  logic [PW-1:0]        norm_p, shf_p;
  logic signed [EW-1:0] be, exp_r;
  int                   sh;
  logic                 lost, g, r, s, inx, inc, tiny, ovf;
  logic [MW-1:0]        k;
  logic [MW:0]          kr;

  assign adv3       = !vld_p3_q | out_ready;
  assign adv2       = !vld_p2_q | adv3;
  assign adv1       = !vld_p1_q | adv2;
  assign in_ready   = adv1 & !RST;
  assign out_valid  = vld_p3_q;
  assign out_result = res_p3_q;
  assign out_flags  = flg_p3_q;
  assign out_tag    = tag_p3_q;

  assign ua = unpack(in_a);
  assign ub = unpack(in_b);

  // Stage 1 special-case resolution, in priority order: NaN, 0*inf, inf, zero.
  always_comb begin
    spc_d     = 1'b1;
    spc_inv_d = 1'b0;
    spc_res_d = '1;
    if (ua.nan | ub.nan)
      spc_inv_d = ua.snan | ub.snan;
    else if ((ua.zero & ub.inf) | (ua.inf & ub.zero))
      spc_inv_d = 1'b1;
    else if (ua.inf | ub.inf)
      spc_res_d = {ua.sign ^ ub.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (ua.zero | ub.zero)
      spc_res_d = {ua.sign ^ ub.sign, {(W-1){1'b0}}};
    else
      spc_d = 1'b0;
  end

  // Stage 1/2 valid bits; reset discards anything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (adv1) vld_p1_q <= in_valid;
      if (adv2) vld_p2_q <= vld_p1_q;
    end
  end

  // Stage 1 register: unpacked operands, special-case result, rm and tag.
  always_ff @(posedge CLK) begin
    if (adv1) begin
      sign_p1_q    <= ua.sign ^ ub.sign;
      ea_p1_q      <= ua.exp;
      eb_p1_q      <= ub.exp;
      ma_p1_q      <= ua.man;
      mb_p1_q      <= ub.man;
      spc_p1_q     <= spc_d;
      spc_inv_p1_q <= spc_inv_d;
      spc_res_p1_q <= spc_res_d;
      rm_p1_q      <= in_rm;
      tag_p1_q     <= in_tag;
    end
  end

  // Stage 2 register: full significand product and exponent sum.
  always_ff @(posedge CLK) begin
    if (adv2) begin
      sign_p2_q    <= sign_p1_q;
      esum_p2_q    <= ea_p1_q + eb_p1_q;
      prod_p2_q    <= PW'(ma_p1_q) * PW'(mb_p1_q);
      spc_p2_q     <= spc_p1_q;
      spc_inv_p2_q <= spc_inv_p1_q;
      spc_res_p2_q <= spc_res_p1_q;
      rm_p2_q      <= rm_p1_q;
      tag_p2_q     <= tag_p1_q;
    end
  end

  // Stage 3 datapath: normalise by one, denormalise if tiny, round, saturate, pack.
  always_comb begin
    if (prod_p2_q[PW-1]) begin
      norm_p = prod_p2_q;
      be     = esum_p2_q + EW'(BIAS + 1);
    end else begin
      norm_p = prod_p2_q << 1;
      be     = esum_p2_q + EW'(BIAS);
    end
    tiny = be[EW-1] | (be == '0);
    sh   = 0;
    if (tiny) begin
      sh = 1 - int'(be);
      if (sh > PW) sh = PW;
    end
    shf_p = norm_p >> sh;
    lost  = |(norm_p ^ (shf_p << sh));
    k     = shf_p[PW-1:MW];
    g     = shf_p[MW-1];
    r     = shf_p[MW-2];
    s     = (|shf_p[MW-3:0]) | lost;
    inx   = g | r | s;
    inc   = rnd_inc(rm_p2_q, sign_p2_q, k[0], g, r, s);
    kr    = {1'b0, k} + {{MW{1'b0}}, inc};
    if (tiny) exp_r = {{(EW-1){1'b0}}, kr[MW-1]};
    else      exp_r = be + {{(EW-1){1'b0}}, kr[MW]};
    ovf = !tiny && (exp_r >= EW'(EMAX));

    res_p3_d = {sign_p2_q, exp_r[EXP_W-1:0], kr[MW-2:0]};
    flg_p3_d = {2'b00, tiny & inx, inx};
    if (spc_p2_q) begin
      res_p3_d = spc_res_p2_q;
      flg_p3_d = {spc_inv_p2_q, 3'b000};
    end else if (ovf) begin
      res_p3_d = sat_ovf(sign_p2_q, rm_p2_q);
      flg_p3_d = 4'b0101;
    end
  end

  // Stage 3 register drives the outputs directly and holds them while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p3_q <= 1'b0;
      res_p3_q <= '0;
      flg_p3_q <= '0;
      tag_p3_q <= '0;
    end else if (adv3) begin
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        res_p3_q <= res_p3_d;
        flg_p3_q <= flg_p3_d;
        tag_p3_q <= tag_p2_q;
      end
    end
  end

endmodule
